// File: rtl/hazard_sequencer.sv
// hazard_sequencer
//   Hazard and sequencing controller for a 5-stage pipelined RISC-V core.
//   - Combinational operand forwarding selects for Execute (M beats W).
//   - Load-use stall and taken-branch flush control.
//   - A small FSM (IDLE/ISSUE/WAIT/DONE) that freezes the front of the
//     pipeline while a multi-cycle CNN accelerator instruction sits in
//     Execute. It issues a one-cycle start pulse and waits for the done
//     pulse, or forces completion after TIMEOUT_CYCLES wait cycles.
//
// Ports
//   clk, rst_n              : clock (rising edge), synchronous active-low reset
//   Rs1D, Rs2D              : source registers of the Decode instruction
//   Rs1E, Rs2E, RdE         : source/destination registers in Execute
//   RdM, RdW                : destination registers in Memory/Writeback
//   RegWriteM, RegWriteW    : register write enables in Memory/Writeback
//   ResultSrcE              : Execute ResultSrc (2'b01 marks a load)
//   PCSrcE                  : taken branch/jump resolved in Execute
//   AccelE                  : Execute holds a CNN accelerator instruction
//   cnn_done                : accelerator completion pulse
//   ForwardAE, ForwardBE    : 00 reg file, 10 ALUResultM, 01 ResultW
//   StallF, StallD, StallE  : hold PC, F/D register, D/E register
//   FlushD, FlushE, FlushM  : clear F/D, D/E, E/M registers
//   cnn_start               : registered one-cycle start pulse
//   cnn_busy                : FSM is not in IDLE
//   cnn_timeout             : sticky flag, a wait ended by timeout

module hazard_sequencer #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] Rs1D,
  input  logic [4:0] Rs2D,
  input  logic [4:0] Rs1E,
  input  logic [4:0] Rs2E,
  input  logic [4:0] RdE,
  input  logic [4:0] RdM,
  input  logic [4:0] RdW,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic [1:0] ResultSrcE,
  input  logic       PCSrcE,
  input  logic       AccelE,
  input  logic       cnn_done,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       FlushD,
  output logic       FlushE,
  output logic       FlushM,
  output logic       cnn_start,
  output logic       cnn_busy,
  output logic       cnn_timeout
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

  // Last counter value reached in WAIT; reaching it forces completion.
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state_r;
  state_t           state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_s;
  logic             start_r;
  logic             start_s;
  logic             timeout_r;
  logic             timeout_s;

  logic             lw_stall_s;
  logic             acc_stall_s;

  // Forwarding select for one Execute source operand; Memory has priority.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic [4:0] rd_m,
    input logic       we_m,
    input logic [4:0] rd_w,
    input logic       we_w
  );
    logic [1:0] sel;
    if (we_m && (rd_m != 5'd0) && (rd_m == rs)) begin
      sel = 2'b10;
    end else if (we_w && (rd_w != 5'd0) && (rd_w == rs)) begin
      sel = 2'b01;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  // State register: FSM state, wait counter, start pulse and sticky timeout.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      cnt_r     <= {CNT_W{1'b0}};
      start_r   <= 1'b0;
      timeout_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      start_r   <= start_s;
      timeout_r <= timeout_s;
    end
  end

  // Next-state logic for the accelerator handshake FSM.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    start_s   = 1'b0;
    timeout_s = timeout_r;
    case (state_r)
      ST_IDLE: begin
        if (AccelE) begin
          state_s = ST_ISSUE;
          start_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        // A done pulse here is ignored; the accelerator answers in WAIT.
        state_s = ST_WAIT;
        cnt_s   = {CNT_W{1'b0}};
      end
      ST_WAIT: begin
        // Counter saturates rather than wrapping.
        if (cnt_r != CNT_MAX) begin
          cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          cnt_s = cnt_r;
        end
        // Done wins over a simultaneous timeout and leaves the flag alone.
        if (cnn_done) begin
          state_s = ST_DONE;
        end else if (cnt_r == CNT_MAX) begin
          state_s   = ST_DONE;
          timeout_s = 1'b1;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Output logic: forwarding, stall/flush equations and status outputs.
  always_comb begin
    ForwardAE  = fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
    ForwardBE  = fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);

    lw_stall_s = (ResultSrcE == 2'b01) && (RdE != 5'd0) &&
                 ((RdE == Rs1D) || (RdE == Rs2D));

    // Stalls release in DONE so the accelerator instruction moves to M.
    case (state_r)
      ST_IDLE:  acc_stall_s = AccelE;
      ST_ISSUE: acc_stall_s = AccelE;
      ST_WAIT:  acc_stall_s = AccelE;
      ST_DONE:  acc_stall_s = 1'b0;
      default:  acc_stall_s = 1'b0;
    endcase

    StallF = lw_stall_s | acc_stall_s;
    StallD = lw_stall_s | acc_stall_s;
    StallE = acc_stall_s;
    FlushM = acc_stall_s;
    FlushD = PCSrcE;
    // The held accelerator instruction must never be flushed out of E.
    FlushE = (lw_stall_s | PCSrcE) & ~acc_stall_s;

    cnn_busy    = (state_r != ST_IDLE);
    cnn_start   = start_r;
    cnn_timeout = timeout_r;
  end

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed testbench for hazard_sequencer (TIMEOUT_CYCLES = 4).
module tb_hazard_sequencer;

  logic       clk;
  logic       rst_n;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic       RegWriteM, RegWriteW;
  logic [1:0] ResultSrcE;
  logic       PCSrcE, AccelE, cnn_done;
  logic [1:0] ForwardAE, ForwardBE;
  logic       StallF, StallD, StallE, FlushD, FlushE, FlushM;
  logic       cnn_start, cnn_busy, cnn_timeout;
  logic [5:0] ctl;

  int n_cmp  = 0;
  int n_fail = 0;

  hazard_sequencer #(.TIMEOUT_CYCLES(4), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .AccelE(AccelE),
    .cnn_done(cnn_done),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
    .cnn_start(cnn_start), .cnn_busy(cnn_busy), .cnn_timeout(cnn_timeout)
  );

  // {StallF, StallD, StallE, FlushD, FlushE, FlushM}
  assign ctl = {StallF, StallD, StallE, FlushD, FlushE, FlushM};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    Rs1D = 5'd0; Rs2D = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0;
    RdE = 5'd0; RdM = 5'd0; RdW = 5'd0;
    RegWriteM = 1'b0; RegWriteW = 1'b0; ResultSrcE = 2'b00;
    PCSrcE = 1'b0; AccelE = 1'b0; cnn_done = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    tick(); tick(); tick();
    n_cmp++;
    if ({ForwardAE, ForwardBE, ctl, cnn_start, cnn_busy, cnn_timeout} !== 13'd0) begin
      $display("FAIL reset_outputs: got %b want 0", {ForwardAE, ForwardBE, ctl, cnn_start, cnn_busy, cnn_timeout});
      n_fail++;
    end
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if ({ctl, cnn_start, cnn_busy, cnn_timeout} !== 9'd0) begin
      $display("FAIL after_reset_idle: got %b want 0", {ctl, cnn_start, cnn_busy, cnn_timeout});
      n_fail++;
    end
  endtask

  task automatic test_forwarding();
    @(negedge clk);
    RdM = 5'd5; RegWriteM = 1'b1; RdW = 5'd5; RegWriteW = 1'b1; Rs1E = 5'd5; Rs2E = 5'd0;
    #1;
    n_cmp++;
    if ({ForwardAE, ForwardBE} !== 4'b1000) begin
      $display("FAIL fwd_m_priority: got %b want 1000", {ForwardAE, ForwardBE});
      n_fail++;
    end
    RdM = 5'd0;
    #1;
    n_cmp++;
    if ({ForwardAE, ForwardBE} !== 4'b0100) begin
      $display("FAIL fwd_w_when_rdm0: got %b want 0100", {ForwardAE, ForwardBE});
      n_fail++;
    end
    RdM = 5'd9; Rs2E = 5'd9; RdW = 5'd5;
    #1;
    n_cmp++;
    if ({ForwardAE, ForwardBE} !== 4'b0110) begin
      $display("FAIL fwd_a_w_b_m: got %b want 0110", {ForwardAE, ForwardBE});
      n_fail++;
    end
    RegWriteW = 1'b0; RegWriteM = 1'b0;
    #1;
    n_cmp++;
    if ({ForwardAE, ForwardBE} !== 4'b0000) begin
      $display("FAIL fwd_no_write: got %b want 0000", {ForwardAE, ForwardBE});
      n_fail++;
    end
    clear_inputs();
  endtask

  task automatic test_load_use();
    @(negedge clk);
    ResultSrcE = 2'b01; RdE = 5'd7; Rs2D = 5'd7;
    #1;
    n_cmp++;
    if (ctl !== 6'b110010) begin
      $display("FAIL load_use_rs2: got %b want 110010", ctl);
      n_fail++;
    end
    RdE = 5'd0;
    #1;
    n_cmp++;
    if (ctl !== 6'b000000) begin
      $display("FAIL load_use_rd0: got %b want 000000", ctl);
      n_fail++;
    end
    RdE = 5'd3; Rs1D = 5'd3; ResultSrcE = 2'b00;
    #1;
    n_cmp++;
    if (ctl !== 6'b000000) begin
      $display("FAIL non_load_match: got %b want 000000", ctl);
      n_fail++;
    end
    ResultSrcE = 2'b01; AccelE = 1'b1;
    #1;
    n_cmp++;
    if (ctl !== 6'b111001) begin
      $display("FAIL load_use_with_accel: got %b want 111001", ctl);
      n_fail++;
    end
    clear_inputs();
  endtask

  task automatic test_branch();
    @(negedge clk);
    PCSrcE = 1'b1;
    #1;
    n_cmp++;
    if (ctl !== 6'b000110) begin
      $display("FAIL branch_flush: got %b want 000110", ctl);
      n_fail++;
    end
    clear_inputs();
  endtask

  task automatic test_accel_handshake();
    @(negedge clk);
    AccelE = 1'b1;
    #1;
    n_cmp++;
    if ({ctl, cnn_start, cnn_busy} !== 8'b11100100) begin
      $display("FAIL hs_idle_accel: got %b want 11100100", {ctl, cnn_start, cnn_busy});
      n_fail++;
    end
    tick(); // ISSUE
    n_cmp++;
    if ({ctl, cnn_start, cnn_busy} !== 8'b11100111) begin
      $display("FAIL hs_issue: got %b want 11100111", {ctl, cnn_start, cnn_busy});
      n_fail++;
    end
    tick(); // WAIT, counter 0
    n_cmp++;
    if ({ctl, cnn_start, cnn_busy} !== 8'b11100101) begin
      $display("FAIL hs_wait_start_low: got %b want 11100101", {ctl, cnn_start, cnn_busy});
      n_fail++;
    end
    tick(); tick(); // WAIT, counter 2: done arrives 3 cycles after start
    cnn_done = 1'b1;
    tick(); // DONE
    cnn_done = 1'b0;
    n_cmp++;
    if ({ctl, cnn_start, cnn_busy, cnn_timeout} !== 9'b000000010) begin
      $display("FAIL hs_done: got %b want 000000010", {ctl, cnn_start, cnn_busy, cnn_timeout});
      n_fail++;
    end
    AccelE = 1'b0;
    tick(); // IDLE
    n_cmp++;
    if ({cnn_busy, cnn_timeout} !== 2'b00) begin
      $display("FAIL hs_back_idle: got %b want 00", {cnn_busy, cnn_timeout});
      n_fail++;
    end
  endtask

  // Done in ISSUE is ignored; done coinciding with the last wait cycle is a
  // normal completion and does not raise the timeout flag.
  task automatic test_done_at_limit();
    @(negedge clk);
    AccelE = 1'b1;
    tick(); // ISSUE
    cnn_done = 1'b1;
    tick(); // WAIT c0
    cnn_done = 1'b0;
    n_cmp++;
    if ({ctl, cnn_busy} !== 7'b1110011) begin
      $display("FAIL done_in_issue_ignored: got %b want 1110011", {ctl, cnn_busy});
      n_fail++;
    end
    tick(); tick(); tick(); // WAIT c3
    cnn_done = 1'b1;
    tick(); // DONE
    cnn_done = 1'b0;
    n_cmp++;
    if ({ctl, cnn_busy, cnn_timeout} !== 8'b00000010) begin
      $display("FAIL done_beats_timeout: got %b want 00000010", {ctl, cnn_busy, cnn_timeout});
      n_fail++;
    end
    AccelE = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    @(negedge clk);
    AccelE = 1'b1;
    tick(); // ISSUE
    tick(); tick(); tick(); tick(); // WAIT c0..c3
    n_cmp++;
    if ({ctl, cnn_busy, cnn_timeout} !== 8'b11100110) begin
      $display("FAIL timeout_4th_wait: got %b want 11100110", {ctl, cnn_busy, cnn_timeout});
      n_fail++;
    end
    tick(); // DONE by timeout
    n_cmp++;
    if ({ctl, cnn_busy, cnn_timeout} !== 8'b00000011) begin
      $display("FAIL timeout_done: got %b want 00000011", {ctl, cnn_busy, cnn_timeout});
      n_fail++;
    end
    AccelE = 1'b0;
    tick();
    // Next normal op, done in the first wait cycle; flag must stay set.
    AccelE = 1'b1;
    tick(); // ISSUE
    tick(); // WAIT c0
    cnn_done = 1'b1;
    tick(); // DONE
    cnn_done = 1'b0;
    n_cmp++;
    if ({ctl, cnn_busy, cnn_timeout} !== 8'b00000011) begin
      $display("FAIL timeout_sticky_done: got %b want 00000011", {ctl, cnn_busy, cnn_timeout});
      n_fail++;
    end
    AccelE = 1'b0;
    tick();
    n_cmp++;
    if ({cnn_busy, cnn_timeout} !== 2'b01) begin
      $display("FAIL timeout_sticky_idle: got %b want 01", {cnn_busy, cnn_timeout});
      n_fail++;
    end
  endtask

  task automatic test_reset_mid_wait();
    @(negedge clk);
    AccelE = 1'b1;
    tick(); tick(); tick(); // WAIT c1
    AccelE = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_cmp++;
    if ({ctl, cnn_start, cnn_busy, cnn_timeout} !== 9'd0) begin
      $display("FAIL reset_mid_wait: got %b want 0", {ctl, cnn_start, cnn_busy, cnn_timeout});
      n_fail++;
    end
    cnn_done = 1'b1;
    tick();
    cnn_done = 1'b0;
    tick();
    n_cmp++;
    if ({cnn_start, cnn_busy, cnn_timeout} !== 3'b000) begin
      $display("FAIL stray_done_idle: got %b want 000", {cnn_start, cnn_busy, cnn_timeout});
      n_fail++;
    end
  endtask

  initial begin
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch();
    test_accel_handshake();
    test_done_at_limit();
    test_timeout();
    test_reset_mid_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
